// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the RS(255,239) encoder control path.
package rs_pkg;
    localparam int RS_N    = 255;
    localparam int RS_K    = 239;
    localparam int RS_NPAR = 16;
    localparam int SYM_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAR
    } rs_state_e;
endpackage

// File: rtl/rs_sym_counter.sv
// Symbol counter: synchronous clear beats enable; tc_o flags count == tc_val_i.
module rs_sym_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == tc_val_i);
endmodule

// File: rtl/rs_enc_ctrl.sv
// Byte-serial RS(255,239) encoder control: feedback symbol, chain enables/clears,
// and the systematic message+parity output stream.
import rs_pkg::*;

module rs_enc_ctrl #(
    parameter int N    = RS_N,
    parameter int K    = RS_K,
    parameter int NPAR = RS_NPAR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    output logic             in_ready,
    input  logic [SYM_W-1:0] r_last,
    output logic [SYM_W-1:0] mr,
    output logic             lfsr_en,
    output logic             lfsr_clr,
    output logic [SYM_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             err_sop
);
    if (NPAR != N - K) begin : g_bad_npar
        $error("rs_enc_ctrl: NPAR must equal N-K");
    end

    localparam logic [7:0] K_TC = 8'(K - 1);
    localparam logic [7:0] P_TC = 8'(NPAR - 1);

    rs_state_e        state_q, state_d;
    logic             clr_q, clr_d;     // post-parity clear cycle pending
    logic             pend_q, pend_d;   // aborting sop symbol waits out the clear
    logic [SYM_W-1:0] held_q, held_d;

    logic             cnt_clr, cnt_en, tc;
    logic             emit, emit_sop, emit_eop, err;
    logic [SYM_W-1:0] emit_data;

    logic [SYM_W-1:0] out_data_q;
    logic             out_valid_q, out_sop_q, out_eop_q, err_q;

    rs_sym_counter #(.W(8)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .tc_val_i ((state_q == PAR) ? P_TC : K_TC),
        .tc_o     (tc)
    );

    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        pend_d    = 1'b0;
        held_d    = held_q;
        in_ready  = 1'b0;
        mr        = '0;
        lfsr_en   = 1'b0;
        lfsr_clr  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        emit      = 1'b0;
        emit_data = '0;
        emit_sop  = 1'b0;
        emit_eop  = 1'b0;
        err       = 1'b0;
        if (rst) begin
            lfsr_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        // chain was cleared last cycle, so r_last is zero here
                        mr        = held_q;
                        lfsr_en   = 1'b1;
                        emit      = 1'b1;
                        emit_data = held_q;
                        emit_sop  = 1'b1;
                        cnt_en    = 1'b1;
                        state_d   = MSG;
                    end else if (clr_q) begin
                        lfsr_clr = 1'b1;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            if (in_sop) begin
                                mr        = in_data;
                                lfsr_en   = 1'b1;
                                emit      = 1'b1;
                                emit_data = in_data;
                                emit_sop  = 1'b1;
                                cnt_en    = 1'b1;
                                state_d   = MSG;
                            end else begin
                                err = 1'b1;
                            end
                        end
                    end
                end
                MSG: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (in_sop) begin
                            err      = 1'b1;
                            lfsr_clr = 1'b1;
                            cnt_clr  = 1'b1;
                            pend_d   = 1'b1;
                            held_d   = in_data;
                            state_d  = IDLE;
                        end else begin
                            mr        = in_data ^ r_last;
                            lfsr_en   = 1'b1;
                            emit      = 1'b1;
                            emit_data = in_data;
                            if (tc) begin
                                cnt_clr = 1'b1;
                                state_d = PAR;
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
                    end
                end
                PAR: begin
                    lfsr_en   = 1'b1;
                    emit      = 1'b1;
                    emit_data = r_last;
                    if (tc) begin
                        emit_eop = 1'b1;
                        cnt_clr  = 1'b1;
                        clr_d    = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_q       <= 1'b0;
            pend_q      <= 1'b0;
            held_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            pend_q      <= pend_d;
            held_q      <= held_d;
            out_data_q  <= emit_data;
            out_valid_q <= emit;
            out_sop_q   <= emit_sop;
            out_eop_q   <= emit_eop;
            err_q       <= err;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign err_sop   = err_q;
endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Scoreboard bench for rs_enc_ctrl, with a behavioural parity chain for the golden frame.
module tb_rs_enc_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_sop, in_ready;
    logic [7:0] r_last, mr, out_data;
    logic       lfsr_en, lfsr_clr, out_valid, out_sop, out_eop, err_sop;

    always #5 clk = ~clk;

    rs_enc_ctrl dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(in_ready), .r_last(r_last), .mr(mr), .lfsr_en(lfsr_en), .lfsr_clr(lfsr_clr),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .err_sop(err_sop)
    );

    typedef struct { logic [7:0] d; logic s; logic e; } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_pass = 0;
    int beats = 0, rdy_low = 0, err_seen = 0, err_exp = 0;
    bit win_rdy = 0, win_en = 0, golden = 0;
    logic [7:0] stub_val = 8'h00;
    logic [7:0] g_lo [0:16];
    logic [7:0] chain [0:15];
    logic [7:0] msg [0:238];
    bit m_msg = 0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    // stage chain stand-in: r[j] <= r[j-1] ^ g[j]*mr
    assign r_last = golden ? chain[15] : stub_val;
    always @(posedge clk) begin
        if (lfsr_clr) begin
            for (int j = 0; j < 16; j++) chain[j] <= 8'h00;
        end else if (lfsr_en) begin
            chain[0] <= gmul(mr, g_lo[0]);
            for (int j = 1; j < 16; j++) chain[j] <= chain[j-1] ^ gmul(mr, g_lo[j]);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            beats++;
            if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_sop", out_sop, e.s);
                chk("out_eop", out_eop, e.e);
            end
        end
        if (err_sop === 1'b1) err_seen++;
    end

    always @(negedge clk) begin
        #2;
        if (win_en && in_ready) chk("en_mirror", lfsr_en, in_valid);
        if (win_rdy && !in_ready) rdy_low++;
    end

    task automatic start_frame(input logic [7:0] d);
        exp_t e;
        e.d = d; e.s = 1'b1; e.e = 1'b0;
        sbq.push_back(e);
        msg[0] = d;
        m_cnt = 1;
        m_msg = 1;
    endtask

    task automatic push_parity();
        logic [7:0] poly [0:254];
        exp_t e;
        for (int i = 0; i < 255; i++) poly[i] = (i < 239) ? msg[i] : 8'h00;
        for (int i = 0; i < 239; i++)
            for (int j = 1; j <= 16; j++) poly[i+j] ^= gmul(poly[i], g_lo[16-j]);
        for (int k = 0; k < 16; k++) begin
            e.d = golden ? poly[239+k] : 8'h00;
            e.s = 1'b0;
            e.e = (k == 15);
            sbq.push_back(e);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic s);
        exp_t e;
        if (!m_msg) begin
            if (s) start_frame(d);
            else err_exp++;
        end else if (s) begin
            err_exp++;
            start_frame(d);
        end else begin
            e.d = d; e.s = 1'b0; e.e = 1'b0;
            sbq.push_back(e);
            msg[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 239) begin
                push_parity();
                m_msg = 0;
            end
        end
    endtask

    // called at a falling edge; returns at the falling edge after the accept
    task automatic send(input logic [7:0] d, input logic s);
        int t;
        in_valid = 1'b1; in_data = d; in_sop = s;
        t = 0;
        #1;
        while (!in_ready && t < 64) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        else model_accept(d, s);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sop = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        g_lo[0] = 8'h01;
        for (int j = 1; j <= 16; j++) g_lo[j] = 8'h00;
        a = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) g_lo[j] = g_lo[j-1] ^ gmul(g_lo[j], a);
            g_lo[0] = gmul(g_lo[0], a);
            a = gmul(a, 8'h02);
        end

        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
        @(negedge clk);
        #1 chk("rst_lfsr_clr", lfsr_clr, 1);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_eop", out_eop, 0);
        chk("rst_err_sop", err_sop, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("idle_lfsr_en", lfsr_en, 0);
        chk("idle_mr", mr, 0);
        @(negedge clk);

        // all-zero frame, r_last stubbed at 0
        beats = 0; rdy_low = 0; win_rdy = 1;
        for (int i = 0; i < 239; i++) send(8'h00, i == 0);
        idle(30);
        win_rdy = 0;
        chk("frame_beats", beats, 255);
        chk("ready_low_cycles", rdy_low, 17);
        chk("sb_empty_zero", sbq.size(), 0);

        // stalls interleaved with accepts
        win_en = 1;
        for (int i = 0; i < 239; i++) begin
            send(8'(i + 1), i == 0);
            if (i % 3 == 0) idle(2);
        end
        idle(25);
        win_en = 0;
        chk("sb_empty_stall", sbq.size(), 0);

        // first symbol without sop in IDLE
        send(8'h55, 1'b0);
        idle(3);
        chk("err_idle_nosop", err_seen, err_exp);
        chk("sb_empty_nosop", sbq.size(), 0);

        // sop at message symbol 50 aborts and restarts
        send(8'h20, 1'b1);
        for (int i = 1; i < 49; i++) send(8'(i + 8'h20), 1'b0);
        in_valid = 1'b1; in_data = 8'h77; in_sop = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_lfsr_clr", lfsr_clr, 1);
        model_accept(8'h77, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0;
        #1;
        chk("clear_in_ready", in_ready, 0);
        chk("restart_lfsr_en", lfsr_en, 1);
        chk("restart_mr", mr, 8'h77);
        @(negedge clk);
        for (int i = 1; i < 239; i++) send(8'(i * 3), 1'b0);
        idle(25);
        chk("err_abort", err_seen, err_exp);
        chk("sb_empty_abort", sbq.size(), 0);

        // feedback math, then reset mid-message at counter=100
        send(8'h10, 1'b1);
        for (int i = 1; i < 100; i++) begin
            if (i == 5) begin
                stub_val = 8'hA5;
                in_valid = 1'b1; in_data = 8'h3C; in_sop = 1'b0;
                #1;
                chk("fb_mr", mr, 8'h99);
                chk("fb_lfsr_en", lfsr_en, 1);
                model_accept(8'h3C, 1'b0);
                @(negedge clk);
                stub_val = 8'h00;
            end else begin
                send(8'(i), 1'b0);
            end
        end
        idle(2);
        chk("sb_empty_prerst", sbq.size(), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_lfsr_clr", lfsr_clr, 1);
            chk("midrst_out_valid", out_valid, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        m_msg = 0; m_cnt = 0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        @(negedge clk);

        // golden encode against polynomial long division
        golden = 1;
        for (int i = 0; i < 239; i++) send(8'(i + 1), i == 0);
        idle(25);
        chk("sb_empty_golden", sbq.size(), 0);
        chk("err_total", err_seen, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs_enc_ctrl.md
Name: rs_enc_ctrl

Overview:
- Byte-serial control and feedback stage of the RS(255,239) encoder over GF(2^8).
- Sits directly upstream of the generator-coefficient stage chain and drives the feedback symbol mr (message XOR last parity register) into every stage.
- Counts message symbols and forces mr to zero during the parity phase.
- Muxes message bytes, then the shifted-out parity bytes, into one systematic codeword stream.

Parameters:
- N, 255, codeword length in symbols.
- K, 239, message length in symbols.
- NPAR, 16, parity symbols; must equal N-K (elaboration-time check).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  message symbol
- in_valid  in  1  in_data valid
- in_sop  in  1  first symbol of a message, qualified by in_valid
- in_ready  out  1  block accepts a symbol this cycle (in_valid & in_ready = accept)
- r_last  in  8  current content of the final parity register from the stage chain
- mr  out  8  feedback symbol to all stages (combinational)
- lfsr_en  out  1  stage chain advances this cycle
- lfsr_clr  out  1  stage chain clears its registers this cycle
- out_data  out  8  codeword symbol
- out_valid  out  1  out_data valid
- out_sop  out  1  first codeword symbol
- out_eop  out  1  last codeword symbol
- err_sop  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, counter=0. in_ready=1 after reset. out_valid, out_sop, out_eop, err_sop and out_data are all 0.
- rst has priority over everything. Reset mid-codeword abandons it with no eop. lfsr_clr=1 while rst is high.
- State IDLE:
  - in_ready=1, mr=0, lfsr_en=0.
  - Accepting a symbol with in_sop=1: mr=in_data (chain was cleared), lfsr_en=1, counter=1, state goes to MSG.
  - The symbol is emitted with out_sop=1.
  - Accepting a symbol with in_sop=0: symbol is dropped, err_sop pulses, state stays IDLE.
- State MSG:
  - in_ready=1.
  - On accept: mr=in_data^r_last, lfsr_en=1, symbol emitted, counter increments.
  - When the K-th symbol is accepted, state goes to PAR and counter resets to 0.
  - A cycle with no accept: lfsr_en=0, mr=0, out_valid=0. The stall is transparent; chain state is held.
  - Accepting a symbol with in_sop=1: current codeword is aborted, err_sop pulses, lfsr_clr=1.
  - That symbol is then treated as the first symbol of a new message (next cycle, after the clear). in_ready=0 for that one clear cycle.
- State PAR:
  - in_ready=0, mr=0, lfsr_en=1 every cycle.
  - out_data=r_last sampled before the shift.
  - Runs for NPAR cycles. On the last one out_eop=1, then state goes to IDLE with lfsr_clr=1 in the transition cycle.
- Output latency: out_* are registered, 1 cycle after the accept/shift cycle. mr, lfsr_en and lfsr_clr are combinational, in the same cycle.
- Counter: 8 bits, saturating logic not needed; compare to K-1 and NPAR-1 explicitly.
- Codeword ordering: K message symbols then NPAR parity symbols, with no bubbles in the parity phase.
- Minimum gap between the eop of one codeword and the sop of the next: 1 cycle (the clear cycle). in_ready is low in that cycle.

Decomposition:
- Shared package rs_pkg holds:
  - constants: RS_N, RS_K, RS_NPAR, SYM_W=8
  - state enum: IDLE, MSG, PAR
- One natural sub-module: rs_sym_counter (8-bit counter with clear, enable and terminal-count compare). All remaining logic stays in rs_enc_ctrl.

Test Plan:
- Reset behaviour: assert rst for 3 cycles mid-MSG (counter=100). Required: out_valid=0, lfsr_clr=1 during reset; state IDLE, in_ready=1 after.
- Feedback math: stub r_last=8'hA5, accept in_data=8'h3C in MSG. Required: mr=8'h99 and lfsr_en=1 in the same cycle; out_data=8'h3C one cycle later.
- Full frame, all-zero message with r_last stubbed at 0:
  - 239 accepted symbols then 16 parity cycles give 255 out_valid beats.
  - out_sop on beat 1, out_eop on beat 255 only.
  - in_ready=0 for exactly 17 cycles (16 parity + 1 clear).
- Stalls: toggle in_valid 1,0,0,1 across the message. Required: lfsr_en mirrors accepts exactly, and the count still terminates at the 239th accept.
- Protocol errors:
  - in_sop=0 on the first symbol in IDLE gives an err_sop pulse and no output.
  - in_sop=1 at message symbol 50 gives an err_sop pulse and lfsr_clr=1, then a new frame starts with out_sop.
- Golden encode: with the real stage chain attached, message bytes 1..239 produce 16 parity bytes matching the reference software RS(255,239) encoder (generator roots alpha^0..alpha^15).
